// File: rtl/approx_mult_err_monitor.sv
// approx_mult_err_monitor
// Exhaustive response analyzer for an external W x W approximate multiplier.
// It sweeps every operand pair into the multiplier and registers each result.
// It then accumulates the error count, the sum of error distances, and the
// maximum error distance together with the first operand pair that reached it.
`timescale 1ns/1ps

module approx_mult_err_monitor #(
    parameter int W  = 8,
    parameter int RW = 2 * W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [W-1:0]      A,
    output logic [W-1:0]      B,
    input  logic [RW-1:0]     R,
    output logic              busy,
    output logic              done,
    output logic [2*W:0]      err_count,
    output logic [RW+2*W-1:0] sum_ed,
    output logic [RW-1:0]     max_ed,
    output logic [W-1:0]      max_a,
    output logic [W-1:0]      max_b
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2*W-1:0] PAIR_INC = 1;
    localparam logic [2*W:0]   CNT_INC  = 1;

    state_t          state, state_nxt;
    logic            drain_cnt;
    logic            start_ok;
    logic            last_pair;
    logic [2*W-1:0]  pair;

    // Stage 1: the result plus the operands that produced it.
    logic            s1_valid;
    logic [W-1:0]    a_d, b_d;
    logic [RW-1:0]   r_d;

    // Stage 2: error distance of the registered pair.
    logic [2*W-1:0]  exact;
    logic signed [RW:0] diff;
    logic [RW:0]     diff_neg;
    logic [RW-1:0]   ed;

    assign pair      = {A, B};
    assign last_pair = &pair;
    assign start_ok  = start && (state == S_IDLE || state == S_DONE);
    assign busy      = (state == S_SWEEP) || (state == S_DRAIN);
    assign done      = (state == S_DONE);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode: sweep, then two drain cycles so the pipeline empties.
    always_comb begin
        // NOTE: default assigned first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        unique case (state)
            S_IDLE, S_DONE: if (start)     state_nxt = S_SWEEP;
            S_SWEEP:        if (last_pair) state_nxt = S_DRAIN;
            S_DRAIN:        if (drain_cnt) state_nxt = S_DONE;
            default:                       state_nxt = S_IDLE;
        endcase
    end

    // Drain cycle counter: 0 in the first DRAIN cycle, 1 in the second.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drain_cnt <= 1'b0;
        else        drain_cnt <= (state == S_DRAIN);
    end

    // Operand generator: B is the inner index; holds all-ones after the last pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A <= '0;
            B <= '0;
        end else if (start_ok) begin
            A <= '0;
            B <= '0;
        end else if (state == S_SWEEP && !last_pair) begin
            {A, B} <= pair + PAIR_INC;
        end
    end

    // Stage 1: capture the multiplier result alongside the operands that made it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            a_d      <= '0;
            b_d      <= '0;
            r_d      <= '0;
        end else begin
            s1_valid <= (state == S_SWEEP);
            a_d      <= A;
            b_d      <= B;
            r_d      <= R;
        end
    end

    // Stage 2 arithmetic: |R - A*B| on one extra bit of signed headroom.
    assign exact    = a_d * b_d;
    assign diff     = $signed({1'b0, r_d}) - $signed({{(RW + 1 - 2 * W){1'b0}}, exact});
    assign diff_neg = -diff;
    assign ed       = diff[RW] ? diff_neg[RW-1:0] : diff[RW-1:0];

    // Accumulators: cleared on an accepted start, updated once per valid pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
            sum_ed    <= '0;
            max_ed    <= '0;
            max_a     <= '0;
            max_b     <= '0;
        end else if (start_ok) begin
            err_count <= '0;
            sum_ed    <= '0;
            max_ed    <= '0;
            max_a     <= '0;
            max_b     <= '0;
        end else if (s1_valid) begin
            if (ed != '0) err_count <= err_count + CNT_INC;
            sum_ed <= sum_ed + {{(2 * W){1'b0}}, ed};
            // Strictly greater: ties keep the earlier pair.
            if (ed > max_ed) begin
                max_ed <= ed;
                max_a  <= a_d;
                max_b  <= b_d;
            end
        end
    end

endmodule
